// File: rtl/arm_mem_pkg.sv
// ============================================================================
// arm_mem_pkg : shared types for the unified IF/DM memory arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package arm_mem_pkg;

    localparam int MEM_LAT_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } mem_arb_state_t;

    typedef enum logic [0:0] {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } mem_owner_t;

endpackage

`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
// ============================================================================
// unified_mem_arbiter : single-port memory arbiter, DM priority over IF,
// fixed CMD/WAIT/RESP access sequence. Optional MEM_ARB_STARVE_GUARD_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module unified_mem_arbiter
    import arm_mem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = MEM_LAT_DEFAULT,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int              CNT_W    = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LAT - 1);

    mem_arb_state_t    state_q, state_d;
    mem_owner_t        owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              we_q, we_d;
    logic              en_q, en_d;
    logic              grant_dm;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve_q, starve_d;
    logic          starved;

    assign starved  = (starve_q == SW'(STARVE_MAX));
    assign grant_dm = dm_req && !(if_req && starved);

    // Counts DM grants that bypassed a waiting IF; only IDLE cycles update it.
    always_comb begin
        starve_d = starve_q;
        if (state_q == IDLE) begin
            if (!if_req) begin
                starve_d = '0;
            end else if (grant_dm) begin
                starve_d = starved ? starve_q : starve_q + SW'(1);
            end else begin
                starve_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) starve_q <= '0;
        else     starve_q <= starve_d;
    end
`else
    assign grant_dm = dm_req;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        en_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (if_req || dm_req) begin
                    state_d = CMD;
                    en_d    = 1'b1;
                    cnt_d   = '0;
                    if (grant_dm) begin
                        owner_d = OWN_DM;
                        addr_d  = dm_addr;
                        wdata_d = dm_wdata;
                        we_d    = dm_we;
                    end else begin
                        owner_d = OWN_IF;
                        addr_d  = if_addr;
                        wdata_d = '0;
                        we_d    = 1'b0;
                    end
                end
            end
            CMD:  state_d = WAIT;
            WAIT: begin
                // The last WAIT cycle is the one where the macro presents data.
                if (cnt_q == LAT_LAST) begin
                    state_d = RESP;
                    rdata_d = mem_rdata;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWN_IF;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            en_q    <= en_d;
        end
    end

    assign mem_en    = en_q;
    assign mem_we    = en_q & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != IDLE);

    assign if_ready  = (state_q == RESP) && (owner_q == OWN_IF);
    assign dm_ready  = (state_q == RESP) && (owner_q == OWN_DM);
    assign if_rdata  = if_ready ? rdata_q : '0;
    assign dm_rdata  = (dm_ready && !we_q) ? rdata_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
// ============================================================================
// tb_unified_mem_arbiter : randomized bench with a transaction-timing model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_unified_mem_arbiter;

    localparam int LAT  = 2;
    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_ready, dm_req, dm_we, dm_ready;
    logic        mem_en, mem_we, busy;
    logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    unified_mem_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .MEM_LAT    (LAT),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_ready  (dm_ready),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: one access in flight, granted at cycle g.
    bit          act      = 1'b0;
    int          g        = 0;
    bit          m_dm     = 1'b0;
    bit          m_we     = 1'b0;
    logic [31:0] m_addr   = '0;
    logic [31:0] m_wdata  = '0;
    bit          post_rst = 1'b0;
    bit          rst_done = 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
    int          streak   = 0;
`endif

    // Requesters
    bit          ir = 1'b0, dr = 1'b0, dw = 1'b0;
    logic [31:0] ia = '0, da = '0, dd = '0;

    // Memory environment
    int          resp_c = -1;
    logic [31:0] resp_d = '0;
    int          if_seen = 0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input int mode);
        logic        exp_en, exp_we, exp_busy, exp_ir, exp_dr, fire, pick_dm;
        logic [31:0] exp_ird, exp_drd;
        @(negedge clk);
        cyc++;
        exp_en = 0; exp_we = 0; exp_busy = 0; exp_ir = 0; exp_dr = 0;
        exp_ird = '0; exp_drd = '0;
        if (act) begin
            exp_en   = (cyc == g + 1);
            exp_we   = exp_en && m_we;
            exp_busy = (cyc >= g + 1) && (cyc <= g + 2 + LAT);
            if (cyc == g + 2 + LAT) begin
                if (m_dm) begin
                    exp_dr  = 1'b1;
                    exp_drd = m_we ? 32'h0 : memf(m_addr);
                end else begin
                    exp_ir  = 1'b1;
                    exp_ird = memf(m_addr);
                end
            end
        end
        check_eq("busy",     busy,     exp_busy);
        check_eq("mem_en",   mem_en,   exp_en);
        check_eq("mem_we",   mem_we,   exp_we);
        check_eq("if_ready", if_ready, exp_ir);
        check_eq("dm_ready", dm_ready, exp_dr);
        check_eq("if_rdata", if_rdata, exp_ird);
        check_eq("dm_rdata", dm_rdata, exp_drd);
        if (exp_busy) check_eq("mem_addr", mem_addr, m_addr);
        if (exp_we)   check_eq("mem_wdata", mem_wdata, m_wdata);
        if (post_rst) begin
            check_eq("rst_mem_addr",  mem_addr,  32'h0);
            check_eq("rst_mem_wdata", mem_wdata, 32'h0);
            post_rst = 1'b0;
        end

        if (mem_en) begin
            resp_c = cyc + LAT;
            resp_d = memf(mem_addr);
        end
        mem_rdata = (cyc == resp_c) ? resp_d : $urandom;

        if (act && cyc == g + 2 + LAT) begin
            if (m_dm) dr = 1'b0;
            else      ir = 1'b0;
        end

        fire = (mode == 0) && act && (cyc == g + 2) && (cyc > 50) &&
               (!rst_done || $urandom_range(0, 7) == 0);
        if (fire) begin
            rst_done = 1'b1;
            act      = 1'b0;
            ir       = 1'b0;
            dr       = 1'b0;
            post_rst = 1'b1;
`ifdef MEM_ARB_STARVE_GUARD_EN
            streak   = 0;
`endif
        end else begin
            if (!ir && (mode == 1 || $urandom_range(0, 2) == 0)) begin
                ir = 1'b1;
                ia = $urandom;
            end
            if (!dr && (mode == 1 || $urandom_range(0, 2) == 0)) begin
                dr = 1'b1;
                dw = 1'($urandom_range(0, 1));
                da = $urandom;
                dd = $urandom;
            end
            if (!act || cyc >= g + 3 + LAT) begin
                act = 1'b0;
                if (ir || dr) begin
                    pick_dm = dr;
`ifdef MEM_ARB_STARVE_GUARD_EN
                    if (!ir) streak = 0;
                    if (ir && streak == SMAX) pick_dm = 1'b0;
                    if (pick_dm && ir) streak = (streak < SMAX) ? streak + 1 : streak;
                    else if (!pick_dm) streak = 0;
`endif
                    act     = 1'b1;
                    g       = cyc;
                    m_dm    = pick_dm;
                    m_addr  = pick_dm ? da : ia;
                    m_we    = pick_dm && dw;
                    m_wdata = pick_dm ? dd : 32'h0;
`ifdef MEM_ARB_STARVE_GUARD_EN
                end else begin
                    streak = 0;
`endif
                end
            end
        end

        rst      = fire;
        if_req   = ir;
        if_addr  = ia;
        dm_req   = dr;
        dm_we    = dw;
        dm_addr  = da;
        dm_wdata = dd;
    endtask

    initial begin
        rst = 1'b1; if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0;
        dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_busy",     busy,      1'b0);
        check_eq("reset_mem_en",   mem_en,    1'b0);
        check_eq("reset_mem_we",   mem_we,    1'b0);
        check_eq("reset_mem_addr", mem_addr,  32'h0);
        check_eq("reset_mem_wd",   mem_wdata, 32'h0);
        check_eq("reset_if_ready", if_ready,  1'b0);
        check_eq("reset_dm_ready", dm_ready,  1'b0);
        check_eq("reset_if_rdata", if_rdata,  32'h0);
        check_eq("reset_dm_rdata", dm_rdata,  32'h0);
        cyc = 0;
        rst = 1'b0;

        for (int i = 0; i < 800; i++) step(0);
        check_eq("reset_in_wait_exercised", rst_done, 1'b1);

        for (int i = 0; i < 150; i++) begin
            step(1);
            if (i >= 20 && if_ready) if_seen++;
        end
`ifdef MEM_ARB_STARVE_GUARD_EN
        check_eq("guard_if_granted", (if_seen != 0), 1'b1);
`else
        check_eq("strict_prio_if_starved", if_seen, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
